module_digit_reg_bank: RTL
==========================

// Module: module_digit_reg_bank
// PURPOSE
//  Parametrised N-digit operand register feeding the display subsystem.
//  Holds one operand as N digits and accepts three commands: parallel load
//  from the arithmetic path, keypad shift-in, and clear. Produces a
//  leading-zero blanking mask and a significant-digit count, and posts
//  updates to the display through a valid/ready handshake.
//  Sits between the keypad/ALU result mux and the 7-segment scan driver.
// PARAMETERS
//  N_DIGITS   4  number of digits held (>=2)
//  DIGIT_W    4  bits per digit
//  BCD_CHECK  1  1: reject pushed keys greater than 9
//  BLANK_EN   1  1: generate leading-zero mask; 0: blank is all zeros
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst        in   1                 asynchronous reset, active-high
//  clr        in   1                 clear operand
//  load       in   1                 parallel load of digits_in
//  digits_in  in   N_DIGITS*DIGIT_W  load data, digit 0 (units) in LSBs
//  push       in   1                 shift key in at the units position
//  key        in   DIGIT_W           digit to push
//  upd_ready  in   1                 display has taken current update
//  digits_out out  N_DIGITS*DIGIT_W  stored operand, digit 0 in LSBs
//  blank      out  N_DIGITS          1 = suppress this digit
//  ndig       out  $clog2(N_DIGITS+1)  significant digits, 0..N_DIGITS
//  full       out  1                 ndig == N_DIGITS
//  err        out  1                 one-cycle pulse: push rejected
//  upd_valid  out  1                 new contents pending for display
// BEHAVIOUR
//  - Reset (async assert, sync release): every output is 0, so blank is 0
//    for the all-zero operand. Outputs are registered. Each command takes
//    effect on the rising edge that samples it and is visible one cycle later.
//  - Priority: clr > load > push. A lower-priority command in the same
//    cycle is dropped silently and gives no err.
//  - clr: digits = 0, ndig = 0. Accepted.
//  - load: digits = digits_in, ndig = index of highest nonzero digit + 1,
//    or 0 when all digits are zero. Accepted. No range check on load.
//  - push: rejected when full, or when BCD_CHECK=1 and key > 9.
//    On reject: state is unchanged and err = 1 for exactly one cycle.
//    Otherwise digits shift up one position (top digit is zero because not
//    full), digit0 = key. ndig increments if ndig > 0 or key != 0.
//    Pushing 0 into an empty operand is accepted and ndig stays 0.
//  - blank (BLANK_EN=1): blank[i] = 1 when digit i and all higher digits are
//    zero, for i >= 1. blank[0] is always 0, so "0" is displayed.
//  - upd_valid: set on the cycle after any accepted command, including one
//    that leaves the value unchanged. Cleared after a cycle with
//    upd_valid && upd_ready and no accepted command that cycle. An accepted
//    command coincident with the handshake keeps upd_valid = 1.
//    A rejected push never sets upd_valid.
//  - Reset mid-operation: state returns to reset values at once and any
//    pending update is discarded.
// STRUCTURE
//  - disp_pkg: DIGIT_W default, BCD_MAX = 9, typedef digit_t =
//    logic [DIGIT_W-1:0], and a function that computes the significant count.
//  - Sub-module module_lz_blank: combinational, digits -> {blank, ndig}.
//    Used on the next-state digits so that blank and ndig are registered
//    together with digits_out.
//  - Top level: command priority decode, digit shift register, handshake flop.
// TESTING (N_DIGITS=4, DIGIT_W=4, BCD_CHECK=1, BLANK_EN=1)
//  1. push 1,2,3 -> digits_out=16'h0123, ndig=3, blank=4'b1000, full=0.
//  2. push 4 then push 5 -> 16'h1234 held, full=1, err high one cycle on
//     the 5, upd_valid not re-set by the rejected push.
//  3. load 16'h0050 with push=1, key=7 same cycle -> 16'h0050, ndig=2,
//     blank=4'b1100, err=0.
//  4. push key=4'hA -> state unchanged, err pulse; then clr ->
//     digits_out=0, ndig=0, blank=4'b1110.
//  5. upd_ready=0 for 5 cycles after push -> upd_valid stays 1; upd_ready=1
//     -> 0 next cycle; repeat with a push coincident with ready -> stays 1.
//  6. rst asserted asynchronously mid-stream between clock edges -> all
//     outputs 0 before the next edge; first push after release works normally.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and helpers for the display operand register
package disp_pkg;

  localparam int DEF_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int MAX_DIGITS  = 16;

  typedef logic [DEF_DIGIT_W-1:0] digit_t;

  // Position of the highest set bit plus one; 0 when no bit is set.
  function automatic int sig_count(input logic [MAX_DIGITS-1:0] nz);
    int c;
    c = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (nz[i]) c = i + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/module_lz_blank.sv
// rtl/module_lz_blank.sv - leading-zero blanking mask and significant-digit count
module module_lz_blank
  import disp_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = DEF_DIGIT_W,
  parameter bit BLANK_EN = 1'b1,
  localparam int NW = $clog2(N_DIGITS + 1)
) (
  input  logic [N_DIGITS*DIGIT_W-1:0] digits,
  output logic [N_DIGITS-1:0]         blank,
  output logic [NW-1:0]               ndig
);

  logic [MAX_DIGITS-1:0] nz;

  always_comb begin
    nz = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      nz[i] = |digits[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign ndig = NW'(sig_count(nz));

  // Digit i is blank exactly when nothing at or above i is significant; units never blank.
  always_comb begin
    blank = '0;
    if (BLANK_EN) begin
      for (int i = 1; i < N_DIGITS; i++) begin
        blank[i] = (int'(ndig) <= i);
      end
    end
  end

endmodule

// File: rtl/module_digit_reg_bank.sv
// rtl/module_digit_reg_bank.sv - N-digit operand register with clear/load/push and display handshake
module module_digit_reg_bank
  import disp_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter bit BCD_CHECK = 1'b1,
  parameter bit BLANK_EN  = 1'b1,
  localparam int NW = $clog2(N_DIGITS + 1),
  localparam int DW = N_DIGITS * DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DW-1:0]      digits_in,
  input  logic               push,
  input  logic [DIGIT_W-1:0] key,
  input  logic               upd_ready,
  output logic [DW-1:0]      digits_out,
  output logic [N_DIGITS-1:0] blank,
  output logic [NW-1:0]      ndig,
  output logic               full,
  output logic               err,
  output logic               upd_valid
);

  logic               key_bad;
  logic               push_ok;
  logic               push_rej;
  logic               accept;
  logic [DW-1:0]      digits_nx;
  logic [N_DIGITS-1:0] blank_nx;
  logic [NW-1:0]      ndig_nx;
  logic               upd_nx;

  assign key_bad  = BCD_CHECK && (key > DIGIT_W'(BCD_MAX));
  assign push_ok  = push && !clr && !load && !full && !key_bad;
  assign push_rej = push && !clr && !load && (full || key_bad);
  assign accept   = clr || load || push_ok;

  always_comb begin
    digits_nx = digits_out;
    if (clr)          digits_nx = '0;
    else if (load)    digits_nx = digits_in;
    else if (push_ok) digits_nx = {digits_out[DW-DIGIT_W-1:0], key};
  end

  module_lz_blank #(
    .N_DIGITS (N_DIGITS),
    .DIGIT_W  (DIGIT_W),
    .BLANK_EN (BLANK_EN)
  ) u_lz_blank (
    .digits (digits_nx),
    .blank  (blank_nx),
    .ndig   (ndig_nx)
  );

  // An accepted command always posts an update, even if it wins over a handshake.
  always_comb begin
    upd_nx = upd_valid;
    if (accept)                      upd_nx = 1'b1;
    else if (upd_valid && upd_ready) upd_nx = 1'b0;
  end

  // Mask/count only move with an accepted command, so the all-zero reset view stays unblanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_out <= '0;
      blank      <= '0;
      ndig       <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      upd_valid  <= 1'b0;
    end else begin
      err       <= push_rej;
      upd_valid <= upd_nx;
      if (accept) begin
        digits_out <= digits_nx;
        blank      <= blank_nx;
        ndig       <= ndig_nx;
        full       <= (ndig_nx == NW'(N_DIGITS));
      end
    end
  end

endmodule
